mux_n_reg: RTL and testbench
============================

Name: mux_n_reg

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with valid/ready handshake on every input channel and on the output.
- Successor to the 32-bit 2:1 combinational selector. Adds channel count, registered output, backpressure, and a round-robin arbitration mode.
- Sits between operand sources and the ALU input stage, where several producers compete for one datapath.

Parameters:
W, 32, data width per channel in bits (>=1)
N, 4, number of input channels (>=2)
SW, $clog2(N), select/channel-index width; derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = explicit select via sel; 1 = round-robin among valid channels
sel  input  SW  channel index used when mode=0
in_data  input  N*W  channel i occupies bits [i*W +: W]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready; combinational
out_data  output  W  registered selected data
out_ch  output  SW  registered index of the channel that produced out_data
out_valid  output  1  registered output valid
out_ready  input  1  downstream ready

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=0, out_ch=0, rr_ptr=N-1. With rr_ptr=N-1, channel 0 has first round-robin priority.
- Load enable: ld = !out_valid || out_ready. The output register accepts a new beat only when ld=1.
- Grant in mode 0:
  - gnt=sel, gnt_v = (sel<N) && in_valid[sel].
  - sel>=N gives no grant; in_ready stays all zero.
- Grant in mode 1:
  - Search channels starting at rr_ptr+1 (mod N), upward with wrap-around.
  - The first channel with in_valid=1 wins.
  - If no channel is valid, gnt_v=0.
- in_ready[i] = ld && gnt_v && (gnt==i). At most one bit of in_ready is set at a time. in_ready must not depend on in_valid of other channels in mode 0.
- Transfer on channel i: in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= in_data[i], out_ch <= i, out_valid <= 1.
- No transfer, ld=1: out_valid <= 0. out_data and out_ch keep their old values.
- Hold: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid are stable.
- Latency and throughput: 1 cycle from input transfer to out_valid. One beat per cycle when out_ready is held high.
- Simultaneous consume and refill: out_ready=1 with a new transfer in the same cycle refills the register, so out_valid stays 1 with new data.
- rr_ptr:
  - Updates to gnt only on a transfer while mode=1.
  - Unchanged in mode 0 and unchanged when there is no transfer.
- Mode or sel change mid-stream: affects only the grant computed in that cycle. Data already registered is never altered.
- Reset asserted mid-operation: the pending output beat is dropped. All state returns to reset values immediately.

Optional Feature:
- Macro: MUX_N_REG_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit), registered with out_data.
  - out_par = even parity (XOR reduction) of the selected in_data. Reset value 0.
  - Follows the same load/hold rules as out_data.
- When undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-beat with out_valid=1.
  - Required: out_valid=0, out_data=0, out_ch=0 immediately. After release with no in_valid, out_valid stays 0.
- Mode 0 select:
  - Stimulus: N=4, W=32, sel=2, in_valid=4'b0110, in_data[2]=32'hDEADBEEF, out_ready=1.
  - Required: in_ready=4'b0100. Next cycle out_valid=1, out_data=DEADBEEF, out_ch=2.
  - Stimulus: sel=1 with in_valid[1]=0.
  - Required: in_ready=0, and out_valid drops to 0.
- Round-robin fairness:
  - Stimulus: mode=1, in_valid=4'b1111 held, out_ready=1.
  - Required: out_ch sequence 0,1,2,3,0 on consecutive cycles.
  - Stimulus: in_valid=4'b1010.
  - Required: out_ch alternates 1,3.
- Backpressure:
  - Stimulus: out_valid=1, out_data=0x11, out_ready=0 for 3 cycles, all in_valid=1.
  - Required: in_ready=0 and out_data=0x11 stable.
  - Stimulus: then out_ready=1.
  - Required: refill in the same cycle with no bubble.
- Out-of-range select:
  - Stimulus: N=3 (SW=2), sel=3, in_valid=3'b111.
  - Required: in_ready=0 and no output beat.
- Parity (MUX_N_REG_PARITY_EN defined):
  - Stimulus: in_data=32'h00000007 transferred.
  - Required: out_par=1.
  - Stimulus: in_data=32'h00000003 transferred.
  - Required: out_par=0.

Source files
------------

// File: rtl/mux_n_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_n_reg: registered N:1 W-bit mux with valid/ready on every channel and   |
// | explicit-select or round-robin grant. Optional out_par: MUX_N_REG_PARITY_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_n_reg #(
  parameter  int W  = 32,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
`ifdef MUX_N_REG_PARITY_EN
  output logic           out_par,
`endif
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [SW:0]   c_N_EXT   = SW'(N) == '0 ? {1'b1, {SW{1'b0}}} : {1'b0, SW'(N)};
  localparam logic [SW-1:0] c_RR_INIT = SW'(N - 1);

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q,  out_data_d;
  logic [SW-1:0]  out_ch_q,    out_ch_d;
  logic [SW-1:0]  rr_ptr_q,    rr_ptr_d;
  logic           out_par_q,   out_par_d;

  logic           w_ld;
  logic           w_sel_valid;
  logic [SW-1:0]  w_gnt;
  logic           w_gnt_v;
  logic           w_xfer;
  logic [W-1:0]   w_sel_data;

  assign w_ld = !out_valid_q || out_ready;

  // Looped lookup keeps an out-of-range sel from indexing past in_valid.
  always_comb begin : p_sel_valid
    w_sel_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        w_sel_valid = in_valid[i];
      end
    end
  end

  always_comb begin : p_grant
    int idx;
    w_gnt   = '0;
    w_gnt_v = 1'b0;
    idx     = 0;
    if (!mode) begin
      w_gnt   = sel;
      w_gnt_v = ({1'b0, sel} < c_N_EXT) && w_sel_valid;
    end else begin
      // Search upward from the channel after the last winner, wrapping.
      for (int k = 1; k <= N; k++) begin
        idx = (int'(rr_ptr_q) + k) % N;
        if (!w_gnt_v && in_valid[idx]) begin
          w_gnt_v = 1'b1;
          w_gnt   = SW'(idx);
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_ready
      assign in_ready[i] = w_ld && w_gnt_v && (w_gnt == SW'(i));
    end
  endgenerate

  // w_gnt_v implies in_valid[w_gnt], so a granted, loadable beat is a transfer.
  assign w_xfer = w_ld && w_gnt_v;

  always_comb begin : p_data_mux
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == SW'(i)) begin
        w_sel_data = in_data[i*W +: W];
      end
    end
  end

  always_comb begin : p_next
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_par_d   = out_par_q;
    rr_ptr_d    = rr_ptr_q;
    if (w_ld) begin
      out_valid_d = w_xfer;
      if (w_xfer) begin
        out_data_d = w_sel_data;
        out_ch_d   = w_gnt;
        out_par_d  = ^w_sel_data;
      end
    end
    if (w_xfer && mode) begin
      rr_ptr_d = w_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_par_q   <= 1'b0;
      rr_ptr_q    <= c_RR_INIT;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_par_q   <= out_par_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef MUX_N_REG_PARITY_EN
  assign out_par = out_par_q;
`else
  logic w_par_unused;
  assign w_par_unused = out_par_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_n_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux_n_reg: scoreboard bench for mux_n_reg (N=4 main DUT, N=3 range DUT) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mux_n_reg;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [1:0]     sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           out_par;

  logic [1:0]     sel3 = '0;
  logic [3*W-1:0] in_data3 = '0;
  logic [2:0]     in_valid3 = '0;
  logic [2:0]     in_ready3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_ch3;
  logic           out_valid3;
  logic           out_ready3 = 1'b1;
  logic           out_par3;

  mux_n_reg #(.W(W), .N(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch),
`ifdef MUX_N_REG_PARITY_EN
    .out_par(out_par),
`endif
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_n_reg #(.W(W), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3),
`ifdef MUX_N_REG_PARITY_EN
    .out_par(out_par3),
`endif
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

`ifndef MUX_N_REG_PARITY_EN
  assign out_par  = 1'b0;
  assign out_par3 = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   ch;
    logic         par;
  } item_t;

  item_t      sb[$];
  item_t      it;
  logic       m_valid = 1'b0;
  logic       m_new   = 1'b0;
  int         m_rr    = N - 1;
  int         g;
  logic       gv;
  logic       ld;
  logic [N-1:0] exp_rdy;

  // Reference model and scoreboard for the N=4 DUT, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_new   = 1'b0;
      m_rr    = N - 1;
      sb.delete();
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_new) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd0, 64'd1);
        end else begin
          it = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(it.d));
          chk("out_ch", 64'(out_ch), 64'(it.ch));
`ifdef MUX_N_REG_PARITY_EN
          chk("out_par", 64'(out_par), 64'(it.par));
`endif
        end
      end
      g  = 0;
      gv = 1'b0;
      if (!mode) begin
        g  = int'(sel);
        gv = in_valid[g];
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!gv && in_valid[(m_rr + k) % N]) begin
            gv = 1'b1;
            g  = (m_rr + k) % N;
          end
        end
      end
      ld      = !m_valid || out_ready;
      exp_rdy = (ld && gv) ? (N'(1) << g) : '0;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      m_new = 1'b0;
      if (ld && gv) begin
        it.d   = in_data[g*W +: W];
        it.ch  = 2'(g);
        it.par = ^in_data[g*W +: W];
        sb.push_back(it);
        m_new   = 1'b1;
        m_valid = 1'b1;
        if (mode) m_rr = g;
      end else if (ld) begin
        m_valid = 1'b0;
      end
    end
  end

  int exp_rr[5]  = '{0, 1, 2, 3, 0};
  int exp_alt[4] = '{3, 1, 3, 1};

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ch", 64'(out_ch), 64'd0);
    step();
    rst_n = 1'b1;

    // Explicit select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0110; out_ready = 1'b1;
    in_data[1*W +: W] = 32'h1111_1111;
    in_data[2*W +: W] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("m0_ready", 64'(in_ready), 64'b0100);
    @(negedge clk);
    chk("m0_valid", 64'(out_valid), 64'd1);
    chk("m0_data", 64'(out_data), 64'hDEAD_BEEF);
    chk("m0_ch", 64'(out_ch), 64'd2);
    step();
    sel = 2'd1; in_valid = 4'b0100;
    @(negedge clk);
    chk("m0_noready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("m0_drop", 64'(out_valid), 64'd0);

    // Round-robin fairness
    step();
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_full", 64'(out_ch), 64'(exp_rr[k]));
    end
    step();
    in_valid = 4'b1010;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_alt", 64'(out_ch), 64'(exp_alt[k]));
    end

    // Backpressure then refill without a bubble
    step();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data[0*W +: W] = 32'h11;
    in_data[1*W +: W] = 32'h22;
    step();
    out_ready = 1'b0; sel = 2'd1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_data", 64'(out_data), 64'h11);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_refill_rdy", 64'(in_ready), 64'b0010);
    @(negedge clk);
    chk("bp_refill_valid", 64'(out_valid), 64'd1);
    chk("bp_refill_data", 64'(out_data), 64'h22);

`ifdef MUX_N_REG_PARITY_EN
    step();
    sel = 2'd0; in_valid = 4'b0001; in_data[0*W +: W] = 32'h7;
    @(negedge clk);
    @(negedge clk);
    chk("par_odd", 64'(out_par), 64'd1);
    step();
    in_data[0*W +: W] = 32'h3;
    @(negedge clk);
    @(negedge clk);
    chk("par_even", 64'(out_par), 64'd0);
`endif

    // Out-of-range select on the N=3 instance
    step();
    sel3 = 2'd2; in_valid3 = 3'b111;
    in_data3[2*W +: W] = 32'h3333;
    @(negedge clk);
    chk("n3_ready_ok", 64'(in_ready3), 64'b100);
    step();
    sel3 = 2'd3;
    @(negedge clk);
    chk("n3_oor_ready", 64'(in_ready3), 64'd0);
    chk("n3_last_data", 64'(out_data3), 64'h3333);
    repeat (2) begin
      @(negedge clk);
      chk("n3_oor_valid", 64'(out_valid3), 64'd0);
    end

    // Random traffic, checked by the scoreboard
    repeat (300) begin
      step();
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    end

    // Reset asserted mid-beat
    step();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    in_data[0*W +: W] = 32'h55;
    step();
    out_ready = 1'b0; in_valid = '0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_data", 64'(out_data), 64'h55);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_data", 64'(out_data), 64'd0);
    chk("async_rst_ch", 64'(out_ch), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", 64'(out_valid), 64'd0);
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
